// File: rtl/usb_pkg.sv
// Shared USB constants for the EP0 descriptor reader: request codes,
// descriptor type codes and the reader state encoding.
package usb_pkg;

   localparam logic [7:0] BMREQ_STD_DEV_IN   = 8'h80;
   localparam logic [7:0] REQ_GET_DESCRIPTOR = 8'h06;

   localparam logic [7:0] DESC_DEVICE = 8'h01;
   localparam logic [7:0] DESC_CONFIG = 8'h02;
   localparam logic [7:0] DESC_STRING = 8'h03;
   localparam logic [7:0] DESC_QUAL   = 8'h06;
   localparam logic [7:0] DESC_OSCFG  = 8'h07;
   localparam logic [7:0] DESC_BOS    = 8'h0F;

   localparam logic [15:0] STRLANG_LEN = 16'd4;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_DECODE   = 3'd1,
      ST_WAIT_REQ = 3'd2,
      ST_SEND     = 3'd3,
      ST_DONE     = 3'd4,
      ST_STALL    = 3'd5
   } state_t;

   function automatic logic [15:0] min16(input logic [15:0] a, input logic [15:0] b);
      return (a < b) ? a : b;
   endfunction

endpackage

// File: rtl/usb_desc_reader.sv
// EP0 GET_DESCRIPTOR responder: decodes the setup packet, picks a descriptor
// from the ROM map and streams it out in MAXPKT-sized IN packets.
module usb_desc_reader
   import usb_pkg::*;
#(
   parameter int MAXPKT    = 64,
   parameter int HSSUPPORT = 1
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        i_setup_valid,
   input  logic [7:0]  i_bmreqtype,
   input  logic [7:0]  i_breq,
   input  logic [15:0] i_wvalue,
   input  logic [15:0] i_wlength,
   input  logic        i_highspeed,
   input  logic [15:0] i_desc_dev_addr,
   input  logic [15:0] i_desc_dev_len,
   input  logic [15:0] i_desc_qual_addr,
   input  logic [15:0] i_desc_qual_len,
   input  logic [15:0] i_desc_fscfg_addr,
   input  logic [15:0] i_desc_fscfg_len,
   input  logic [15:0] i_desc_hscfg_addr,
   input  logic [15:0] i_desc_hscfg_len,
   input  logic [15:0] i_desc_oscfg_addr,
   input  logic [15:0] i_desc_strlang_addr,
   input  logic [15:0] i_desc_strvendor_addr,
   input  logic [15:0] i_desc_strvendor_len,
   input  logic [15:0] i_desc_strproduct_addr,
   input  logic [15:0] i_desc_strproduct_len,
   input  logic [15:0] i_desc_strserial_addr,
   input  logic [15:0] i_desc_strserial_len,
   input  logic [15:0] i_desc_bos_addr,
   input  logic [15:0] i_desc_bos_len,
   input  logic        i_descrom_have_strings,
   output logic [15:0] o_descrom_raddr,
   input  logic [7:0]  i_descrom_rdat,
   input  logic        i_pkt_req,
   input  logic        i_pkt_retry,
   output logic [7:0]  o_tx_data,
   output logic        o_tx_valid,
   input  logic        i_tx_ready,
   output logic        o_tx_last,
   output logic        o_zlp,
   output logic        o_stall,
   output logic        o_ignore,
   output logic        o_busy,
   output state_t      o_dbg_state
);

   // Byte stream: a byte moves on every cycle where o_tx_valid & i_tx_ready;
   // while valid is high and ready low, data/last hold (ptr does not move).

   localparam logic [15:0] MAXPKT16 = 16'(MAXPKT);
   localparam logic [6:0]  LAST_CNT = 7'(MAXPKT - 1);
   localparam bit          HS_EN    = (HSSUPPORT != 0);

   state_t      state;
   logic [7:0]  bmreq_q;
   logic [7:0]  breq_q;
   logic [15:0] wvalue_q;
   logic [15:0] wlength_q;
   logic [15:0] ptr;
   logic [15:0] remaining;
   logic [15:0] pkt_start;
   logic [15:0] pkt_rem;
   logic [6:0]  pkt_cnt;
   logic        need_zlp;
   logic        tx_valid_q;
   logic        zlp_q;
   logic        stall_q;
   logic        ignore_q;
   logic        busy_q;

   logic        req_ok;
   logic        desc_ok;
   logic [15:0] sel_addr;
   logic [15:0] sel_len;
   logic [15:0] xfer_len;
   logic        zlp_needed;
   logic        pkt_last;
   logic        beat;
   logic [7:0]  desc_type;
   logic [7:0]  desc_idx;

   assign desc_type = wvalue_q[15:8];
   assign desc_idx  = wvalue_q[7:0];
   assign req_ok    = (bmreq_q == BMREQ_STD_DEV_IN) && (breq_q == REQ_GET_DESCRIPTOR);

   // Descriptor map; the speed-dependent entries follow the live link speed.
   always_comb begin
      desc_ok  = 1'b0;
      sel_addr = 16'd0;
      sel_len  = 16'd0;
      case (desc_type)
         DESC_DEVICE: begin
            desc_ok  = 1'b1;
            sel_addr = i_desc_dev_addr;
            sel_len  = i_desc_dev_len;
         end
         DESC_CONFIG: begin
            desc_ok  = (desc_idx == 8'd0);
            sel_addr = i_highspeed ? i_desc_hscfg_addr : i_desc_fscfg_addr;
            sel_len  = i_highspeed ? i_desc_hscfg_len  : i_desc_fscfg_len;
         end
         DESC_STRING: begin
            desc_ok = i_descrom_have_strings && (desc_idx <= 8'd3);
            case (desc_idx)
               8'd0: begin
                  sel_addr = i_desc_strlang_addr;
                  sel_len  = STRLANG_LEN;
               end
               8'd1: begin
                  sel_addr = i_desc_strvendor_addr;
                  sel_len  = i_desc_strvendor_len;
               end
               8'd2: begin
                  sel_addr = i_desc_strproduct_addr;
                  sel_len  = i_desc_strproduct_len;
               end
               8'd3: begin
                  sel_addr = i_desc_strserial_addr;
                  sel_len  = i_desc_strserial_len;
               end
               default: begin
                  sel_addr = 16'd0;
                  sel_len  = 16'd0;
               end
            endcase
         end
         DESC_QUAL: begin
            desc_ok  = HS_EN;
            sel_addr = i_desc_qual_addr;
            sel_len  = i_desc_qual_len;
         end
         DESC_OSCFG: begin
            // Other-speed config describes the speed we are NOT running at.
            desc_ok  = HS_EN && (desc_idx == 8'd0);
            sel_addr = i_desc_oscfg_addr;
            sel_len  = i_highspeed ? i_desc_fscfg_len : i_desc_hscfg_len;
         end
         DESC_BOS: begin
            desc_ok  = 1'b1;
            sel_addr = i_desc_bos_addr;
            sel_len  = i_desc_bos_len;
         end
         default: begin
            desc_ok  = 1'b0;
            sel_addr = 16'd0;
            sel_len  = 16'd0;
         end
      endcase
   end

   assign xfer_len   = min16(wlength_q, sel_len);
   assign zlp_needed = ((xfer_len % MAXPKT16) == 16'd0) && (wlength_q > sel_len);
   assign pkt_last   = (pkt_cnt == LAST_CNT) || (remaining == 16'd1);
   assign beat       = tx_valid_q & i_tx_ready;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state      <= ST_IDLE;
         bmreq_q    <= 8'd0;
         breq_q     <= 8'd0;
         wvalue_q   <= 16'd0;
         wlength_q  <= 16'd0;
         ptr        <= 16'd0;
         remaining  <= 16'd0;
         pkt_start  <= 16'd0;
         pkt_rem    <= 16'd0;
         pkt_cnt    <= 7'd0;
         need_zlp   <= 1'b0;
         tx_valid_q <= 1'b0;
         zlp_q      <= 1'b0;
         stall_q    <= 1'b0;
         ignore_q   <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         zlp_q    <= 1'b0;
         ignore_q <= 1'b0;
         if (i_setup_valid) begin
            // A new setup always wins and silently drops any packet in flight.
            bmreq_q    <= i_bmreqtype;
            breq_q     <= i_breq;
            wvalue_q   <= i_wvalue;
            wlength_q  <= i_wlength;
            stall_q    <= 1'b0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b1;
            state      <= ST_DECODE;
         end else begin
            case (state)
               ST_IDLE: begin
                  busy_q <= 1'b0;
               end
               ST_DECODE: begin
                  if (!req_ok) begin
                     ignore_q <= 1'b1;
                     busy_q   <= 1'b0;
                     state    <= ST_IDLE;
                  end else if (!desc_ok) begin
                     stall_q <= 1'b1;
                     busy_q  <= 1'b0;
                     state   <= ST_STALL;
                  end else begin
                     ptr       <= sel_addr;
                     remaining <= xfer_len;
                     need_zlp  <= zlp_needed;
                     pkt_cnt   <= 7'd0;
                     state     <= ST_WAIT_REQ;
                  end
               end
               ST_WAIT_REQ: begin
                  if (i_pkt_retry) begin
                     ptr       <= pkt_start;
                     remaining <= pkt_rem;
                  end else if (i_pkt_req) begin
                     pkt_start <= ptr;
                     pkt_rem   <= remaining;
                     pkt_cnt   <= 7'd0;
                     if (remaining != 16'd0) begin
                        tx_valid_q <= 1'b1;
                        state      <= ST_SEND;
                     end else begin
                        zlp_q    <= 1'b1;
                        need_zlp <= 1'b0;
                        busy_q   <= 1'b0;
                        state    <= ST_DONE;
                     end
                  end
               end
               ST_SEND: begin
                  if (beat) begin
                     ptr       <= ptr + 16'd1;
                     remaining <= remaining - 16'd1;
                     pkt_cnt   <= pkt_cnt + 7'd1;
                     if (pkt_last) begin
                        tx_valid_q <= 1'b0;
                        if ((remaining != 16'd1) || need_zlp) begin
                           state <= ST_WAIT_REQ;
                        end else begin
                           busy_q <= 1'b0;
                           state  <= ST_DONE;
                        end
                     end
                  end
               end
               ST_DONE: begin
                  if (i_pkt_retry) begin
                     ptr       <= pkt_start;
                     remaining <= pkt_rem;
                     busy_q    <= 1'b1;
                     state     <= ST_WAIT_REQ;
                  end else begin
                     busy_q <= 1'b0;
                     state  <= ST_IDLE;
                  end
               end
               ST_STALL: begin
                  stall_q <= 1'b1;
               end
               default: begin
                  state <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign o_descrom_raddr = ptr;
   assign o_tx_data       = i_descrom_rdat;
   assign o_tx_valid      = tx_valid_q;
   assign o_tx_last       = tx_valid_q & pkt_last;
   assign o_zlp           = zlp_q;
   assign o_stall         = stall_q;
   assign o_ignore        = ignore_q;
   assign o_busy          = busy_q;
   assign o_dbg_state     = state;

endmodule
